// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the MEM stage of an RV32I pipeline. Serves
// byte / half / word loads and stores on a little-endian, word-organised RAM.
// Accesses that cross a word boundary are split into two beats; busy is held
// for the cycle between them so the core can stall.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_re     load request
//   req_we     store request
//   req_mode   funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr   byte address
//   req_wdata  store data (low byte / half / word used according to size)
//   rsp_rdata  registered, extended load result (0 for stores and errors)
//   rsp_valid  one-cycle completion pulse per accepted request
//   busy       second beat pending; request inputs are ignored
//   err        qualifies rsp_valid: the request was illegal
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_valid,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH_WORDS];

  // Context carried from the first beat of a crossing access to the second.
  logic [IDX_W-1:0] next_idx_q;
  logic [1:0]       off_q;
  logic [2:0]       mode_q;
  logic             is_load_q;
  logic [31:0]      partial_q;
  logic [31:0]      wdata_hi_q;
  logic [3:0]       be_hi_q;

  logic [IDX_W-1:0] w;
  logic [1:0]       o;
  logic [3:0]       size_bytes;
  logic [3:0]       size_mask;
  logic             crossing;
  logic             illegal;
  logic [63:0]      wdata_sh;
  logic [7:0]       be_all;
  logic [31:0]      ld_shift;
  logic [31:0]      assembled;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] mode);
    case (mode)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Request decode. Store data and byte enables are laid out across a
  // two-word window: the low half targets word w, the high half word w+1.
  always_comb begin
    w          = req_addr[ADDR_W-1:2];
    o          = req_addr[1:0];
    size_bytes = 4'd4;
    size_mask  = 4'b1111;
    case (req_mode[1:0])
      2'b00:   begin size_bytes = 4'd1; size_mask = 4'b0001; end
      2'b01:   begin size_bytes = 4'd2; size_mask = 4'b0011; end
      default: begin size_bytes = 4'd4; size_mask = 4'b1111; end
    endcase
    crossing = ({2'b00, o} + size_bytes) > 4'd4;
    illegal  = (req_re && req_we)
            || (req_re && (req_mode == 3'b011 || req_mode[2:1] == 2'b11))
            || (req_we && (req_mode[2] || req_mode[1:0] == 2'b11));
    wdata_sh = {32'h0, req_wdata} << {o, 3'b000};
    be_all   = {4'b0000, size_mask} << o;
    ld_shift = mem[w] >> {o, 3'b000};
  end

  // Splice the bytes of word w+1 above the upper bytes latched in beat one.
  always_comb begin
    case (off_q)
      2'd1:    assembled = {mem[next_idx_q][7:0],  partial_q[31:8]};
      2'd2:    assembled = {mem[next_idx_q][15:0], partial_q[31:16]};
      2'd3:    assembled = {mem[next_idx_q][23:0], partial_q[31:24]};
      default: assembled = partial_q;
    endcase
  end

  // RAM write port. Gated by reset so that a request held across an aborting
  // reset edge neither completes its second beat nor restarts its first.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = w;
    wr_be   = 4'b0000;
    wr_data = wdata_sh[31:0];
    if (!reset) begin
      if (state == SECOND) begin
        if (!is_load_q) begin
          wr_en   = 1'b1;
          wr_idx  = next_idx_q;
          wr_be   = be_hi_q;
          wr_data = wdata_hi_q;
        end
      end else if (req_we && !req_re && !illegal) begin
        wr_en = 1'b1;
        wr_be = be_all[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rsp_rdata  <= 32'h0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      next_idx_q <= '0;
      off_q      <= 2'd0;
      mode_q     <= 3'd0;
      is_load_q  <= 1'b0;
      partial_q  <= 32'h0;
      wdata_hi_q <= 32'h0;
      be_hi_q    <= 4'b0000;
    end else begin
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (req_re || req_we) begin
            if (illegal) begin
              rsp_valid <= 1'b1;
              err       <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (crossing) begin
              state      <= SECOND;
              busy       <= 1'b1;
              next_idx_q <= w + 1'b1;
              off_q      <= o;
              mode_q     <= req_mode;
              is_load_q  <= req_re;
              partial_q  <= mem[w];
              wdata_hi_q <= wdata_sh[63:32];
              be_hi_q    <= be_all[7:4];
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= req_re ? extend(ld_shift, req_mode) : 32'h0;
            end
          end
        end
        SECOND: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= is_load_q ? extend(assembled, mode_q) : 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Self-checking bench for dmem_responder: reset state, a table of directed
// vectors, reset-abort sequences, then randomized traffic checked against a
// byte-array reference model of the memory.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_re;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_valid;
  logic        busy;
  logic        err;

  int check_count;
  int pass_count;

  logic [7:0] ref_mem [1024];

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  mode;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[22];

  dmem_responder #(.DEPTH_WORDS(256), .ADDR_W(10)) dut (
    .clk(clk),
    .reset(reset),
    .req_re(req_re),
    .req_we(req_we),
    .req_mode(req_mode),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata),
    .rsp_valid(rsp_valid),
    .busy(busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Called at a falling edge. Holds the request until a response appears,
  // bounded to four cycles; lat = 0 means no response was seen.
  task automatic applyStimulus(input logic re, input logic we, input logic [2:0] mode,
                               input logic [9:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic e, output int lat,
                               output logic busy_first, output logic busy_rsp);
    req_re    = re;
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    lat = 0;
    busy_first = 1'b0;
    busy_rsp = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) busy_first = busy;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    rdata    = rsp_rdata;
    e        = err;
    busy_rsp = busy;
    req_re   = 1'b0;
    req_we   = 1'b0;
  endtask

  task automatic doAndCheck(input string name, input logic re, input logic we, input logic [2:0] mode,
                            input logic [9:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic        b1;
    logic        b2;
    applyStimulus(re, we, mode, addr, wdata, rd, e, lat, b1, b2);
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_busy_first"}, {31'h0, b1}, {31'h0, exp_lat == 2});
    checkOutput({name, "_busy_at_rsp"}, {31'h0, b2}, 32'h0);
    checkOutput({name, "_err"}, {31'h0, e}, {31'h0, exp_err});
    checkOutput({name, "_rdata"}, rd, exp_rdata);
  endtask

  function automatic int sizeOf(input logic [2:0] mode);
    case (mode[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic isIllegal(input logic re, input logic we, input logic [2:0] mode);
    if (re && we) return 1'b1;
    if (re && (mode == 3 || mode == 6 || mode == 7)) return 1'b1;
    if (we && mode > 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] mode, input logic [9:0] addr);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < sizeOf(mode); k++)
      v = v | (32'(ref_mem[(int'(addr) + k) % 1024]) << (8 * k));
    if (mode == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
    if (mode == 3'b001 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic modelStore(input logic [2:0] mode, input logic [9:0] addr, input logic [31:0] wdata);
    for (int k = 0; k < sizeOf(mode); k++)
      ref_mem[(int'(addr) + k) % 1024] = 8'(wdata >> (8 * k));
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic        b1;
    logic        b2;
    int          seen;
    logic        re;
    logic        we;
    logic [2:0]  mode;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_e;
    int          exp_lat;
    int          r;
    logic [2:0]  load_modes [5];

    check_count = 0;
    pass_count  = 0;
    load_modes[0] = 3'b000; load_modes[1] = 3'b001; load_modes[2] = 3'b010;
    load_modes[3] = 3'b100; load_modes[4] = 3'b101;

    //                re    we    mode    addr     wdata         exp_rdata     err   lat
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 10'h004, 32'hDEADBEEF, 32'h00000000, 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 3'b010, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0, 1};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 10'h007, 32'h0,        32'hFFFFFFDE, 1'b0, 1};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 10'h007, 32'h0,        32'h000000DE, 1'b0, 1};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 10'h006, 32'h0,        32'hFFFFDEAD, 1'b0, 1};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 10'h006, 32'h0,        32'h0000DEAD, 1'b0, 1};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 10'h004, 32'h0,        32'hFFFFFFEF, 1'b0, 1};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 10'h008, 32'h0,        32'h00000000, 1'b0, 1};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 10'h00C, 32'h0,        32'h00000000, 1'b0, 1};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 10'h00A, 32'h11223344, 32'h00000000, 1'b0, 2};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 10'h008, 32'h0,        32'h33440000, 1'b0, 1};
    vecs[11] = '{1'b1, 1'b0, 3'b010, 10'h00C, 32'h0,        32'h00001122, 1'b0, 1};
    vecs[12] = '{1'b1, 1'b0, 3'b010, 10'h00A, 32'h0,        32'h11223344, 1'b0, 2};
    vecs[13] = '{1'b0, 1'b1, 3'b001, 10'h3FF, 32'h0000ABCD, 32'h00000000, 1'b0, 2};
    vecs[14] = '{1'b1, 1'b0, 3'b100, 10'h3FF, 32'h0,        32'h000000CD, 1'b0, 1};
    vecs[15] = '{1'b1, 1'b0, 3'b100, 10'h000, 32'h0,        32'h000000AB, 1'b0, 1};
    vecs[16] = '{1'b1, 1'b1, 3'b010, 10'h004, 32'h12345678, 32'h00000000, 1'b1, 1};
    vecs[17] = '{1'b1, 1'b0, 3'b010, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0, 1};
    vecs[18] = '{1'b1, 1'b0, 3'b011, 10'h004, 32'h0,        32'h00000000, 1'b1, 1};
    vecs[19] = '{1'b1, 1'b0, 3'b010, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0, 1};
    vecs[20] = '{1'b0, 1'b1, 3'b100, 10'h004, 32'h12345678, 32'h00000000, 1'b1, 1};
    vecs[21] = '{1'b1, 1'b0, 3'b010, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0, 1};

    reset = 1'b1;
    req_re = 1'b0;
    req_we = 1'b0;
    req_mode = 3'b000;
    req_addr = 10'h0;
    req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_err", {31'h0, err}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // RAM is not reset: clear it so the model and the DUT agree everywhere.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b1, 3'b010, 10'(i * 4), 32'h0, rd, e, lat, b1, b2);
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    $display("[TB] directed vectors");
    for (int i = 0; i < 22; i++) begin
      doAndCheck($sformatf("vec%0d", i), vecs[i].re, vecs[i].we, vecs[i].mode, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
      if (vecs[i].we && !vecs[i].re && !vecs[i].exp_err)
        modelStore(vecs[i].mode, vecs[i].addr, vecs[i].wdata);
    end

    // rsp_valid and err must drop once the request is withdrawn.
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("idle_err", {31'h0, err}, 32'h0);

    $display("[TB] reset during second beat of a load");
    req_re = 1'b1;
    req_mode = 3'b010;
    req_addr = 10'h00A;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ld_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("abort_ld_busy", {31'h0, busy}, 32'h0);
    checkOutput("abort_ld_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("abort_ld_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req_re = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("abort_ld_no_rsp", seen, 0);
    doAndCheck("abort_ld_follow", 1'b1, 1'b0, 3'b010, 10'h004, 32'h0, 32'hDEADBEEF, 1'b0, 1);

    $display("[TB] reset during second beat of a store");
    req_we = 1'b1;
    req_mode = 3'b010;
    req_addr = 10'h012;
    req_wdata = 32'h44332211;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_st_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("abort_st_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req_we = 1'b0;
    @(negedge clk);
    ref_mem[10'h012] = 8'h11;
    ref_mem[10'h013] = 8'h22;
    doAndCheck("abort_st_word4", 1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 32'h22110000, 1'b0, 1);
    doAndCheck("abort_st_word5", 1'b1, 1'b0, 3'b010, 10'h014, 32'h0, 32'h00000000, 1'b0, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      re = 1'b0;
      we = 1'b0;
      if (r <= 3) begin
        re = 1'b1;
        mode = load_modes[$urandom_range(0, 4)];
      end else if (r <= 7) begin
        we = 1'b1;
        mode = 3'($urandom_range(0, 2));
      end else if (r == 8) begin
        re = $urandom_range(0, 1) == 1;
        we = !re;
        mode = 3'($urandom_range(0, 7));
      end else begin
        re = 1'b1;
        we = 1'b1;
        mode = 3'($urandom_range(0, 7));
      end
      addr = 10'($urandom_range(0, 1023));
      wdata = $urandom;
      exp_e = isIllegal(re, we, mode);
      exp_lat = (!exp_e && (int'(addr % 4) + sizeOf(mode) > 4)) ? 2 : 1;
      exp_rd = (exp_e || we) ? 32'h0 : modelLoad(mode, addr);
      doAndCheck($sformatf("rand%0d", i), re, we, mode, addr, wdata, exp_rd, exp_e, exp_lat);
      if (we && !exp_e) modelStore(mode, addr, wdata);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
